instruction_fetch: RTL and testbench

Fetch stage that drives the instruction memory: holds the program counter, presents it as the read address, and captures the returned instruction word with its PC into a one-entry output register. Downstream consumption uses a valid/ready handshake. Redirect (branch/jump) requests flush the held word and reload the PC. The block sits between `instruction_memory` (combinational read) and the decode stage.

---
 rtl/instruction_fetch.sv | 179 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage between a combinational instruction memory and the decode stage.
// Holds the program counter, presents it as the memory read address and
// captures the returned word, together with its PC, into a one-entry output
// register. The consumer takes the word with a valid/ready handshake.
// A redirect reloads the PC and flushes the held word.
//
// Optional feature macro: FETCH_BOUNDS_CHECK_EN
//   defined   : a fetch with pc >= MEM_BYTES captures nothing, drops out_valid
//               and enters a sticky FAULT state (fault = 1) until reset; no
//               further fetches are made and redirects are ignored.
//   undefined : no range check, fetch runs past MEM_BYTES, fault is tied 0.
//
// Parameters
//   RESET_PC   PC value loaded on reset
//   MEM_BYTES  instruction memory size in bytes (bounds check only)
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-high reset
//   imem_addr       out  byte address to instruction memory (the PC register)
//   imem_instr      in   instruction word for imem_addr (combinational)
//   redirect_valid  in   load redirect_pc this cycle, flush the output register
//   redirect_pc     in   redirect target, bits [1:0] ignored
//   out_valid       out  out_instr / out_pc hold a valid word
//   out_ready       in   downstream accepts the word while out_valid is high
//   out_instr       out  captured instruction word
//   out_pc          out  byte address of out_instr
//   fault           out  sticky out-of-range fetch flag
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  // A memory that is not a whole number of words cannot be fetched cleanly.
  if ((MEM_BYTES % 4) != 0) begin : g_bad_mem_bytes
    $error("instruction_fetch: MEM_BYTES must be a multiple of 4");
  end

  // Architectural state
  logic [31:0] r_pc;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic [31:0] r_out_pc;
  logic        r_fault;

  // Redirect target forced to word alignment; masking keeps every bit of the
  // input referenced while discarding the byte offset.
  logic [31:0] w_redirect_target;
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Next sequential PC; 32-bit add wraps 32'hFFFF_FFFC -> 0 naturally.
  logic [31:0] w_pc_next;
  assign w_pc_next = r_pc + 32'd4;

  // Fetch is allowed when the output slot is empty or being drained.
  logic w_load;

`ifdef FETCH_BOUNDS_CHECK_EN

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  // 33-bit limit so MEM_BYTES up to 2^32 compares without truncation.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t r_state;
  logic   w_out_of_range;

  assign w_out_of_range = ({1'b0, r_pc} >= MEM_LIMIT);
  assign w_load         = (r_state == ST_RUN) && (!r_out_valid || out_ready);

  // Fetch FSM: redirect has priority over load; an out-of-range load faults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0000_0000;
      r_out_pc    <= 32'h0000_0000;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (redirect_valid) begin
            // A word handshaken this cycle is still consumed downstream;
            // only the slot is emptied here.
            r_pc        <= w_redirect_target;
            r_out_valid <= 1'b0;
          end else if (w_load) begin
            if (w_out_of_range) begin
              // Nothing captured; PC stays at the offending address.
              r_out_valid <= 1'b0;
              r_fault     <= 1'b1;
              r_state     <= ST_FAULT;
            end else begin
              r_out_instr <= imem_instr;
              r_out_pc    <= r_pc;
              r_out_valid <= 1'b1;
              r_pc        <= w_pc_next;
            end
          end else begin
            // Stall: held word must stay stable.
            r_out_valid <= r_out_valid;
          end
        end
        ST_FAULT: begin
          // Sticky until reset; redirects and fetches are ignored.
          r_out_valid <= 1'b0;
          r_fault     <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park in the safe, non-fetching state.
          r_out_valid <= 1'b0;
          r_fault     <= 1'b1;
          r_state     <= ST_FAULT;
        end
      endcase
    end
  end

`else

  assign w_load = !r_out_valid || out_ready;

  // Fetch register update: redirect first, then load, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0000_0000;
      r_out_pc    <= 32'h0000_0000;
      r_fault     <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      if (redirect_valid) begin
        // A word handshaken this cycle is still consumed downstream;
        // only the slot is emptied here.
        r_pc        <= w_redirect_target;
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_instr <= imem_instr;
        r_out_pc    <= r_pc;
        r_out_valid <= 1'b1;
        r_pc        <= w_pc_next;
      end else begin
        // Stall: held word must stay stable.
        r_out_valid <= r_out_valid;
      end
    end
  end

`endif

  // All outputs come straight from registers.
  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign fault     = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed, table-driven bench for instruction_fetch. The memory model returns
// 32'hA000_0000 + word_index for every address. Each vector gives the inputs
// for one clock edge and the outputs expected just after that edge.
// Hand-written sequences cover reset state and asynchronous mid-cycle reset.
// Expectations past MEM_BYTES depend on FETCH_BOUNDS_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    logic        efault;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  // Combinational instruction memory model.
  assign imem_instr = 32'hA000_0000 + {2'b00, imem_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic [31:0] einstr,
                              input logic [31:0] eaddr, input logic efault);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.eaddr = eaddr; v.efault = efault;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] einstr, input logic [31:0] eaddr, input logic efault);
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({tag, " out_pc"}, out_pc, epc);
    check({tag, " out_instr"}, out_instr, einstr);
    check({tag, " imem_addr"}, imem_addr, eaddr);
    check({tag, " fault"}, {31'd0, fault}, {31'd0, efault});
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Streaming from reset
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 32'hA000_0000, 32'h04, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 32'hA000_0001, 32'h08, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 32'hA000_0002, 32'h0C, 1'b0));
    // Three stall cycles holding out_pc = 8
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 32'hA000_0002, 32'h0C, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 32'hA000_0002, 32'h0C, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 32'hA000_0002, 32'h0C, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 32'hA000_0003, 32'h10, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hA000_0004, 32'h14, 1'b0));
    // Redirect back to 0, then restream
    vecs.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 32'h10, 32'hA000_0004, 32'h00, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 32'hA000_0000, 32'h04, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 32'hA000_0001, 32'h08, 1'b0));
    // Redirect to 0x20 while out_pc = 4 is accepted: one bubble, then target
    vecs.push_back(mk(1'b1, 32'h20, 1'b1, 1'b0, 32'h04, 32'hA000_0001, 32'h20, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hA000_0008, 32'h24, 1'b0));
    // Stall, then redirect to 0x23 during stall drops the held word
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'hA000_0008, 32'h24, 1'b0));
    vecs.push_back(mk(1'b1, 32'h23, 1'b0, 1'b0, 32'h20, 32'hA000_0008, 32'h20, 1'b0));
    // Empty slot loads even with out_ready low
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'hA000_0008, 32'h24, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 32'hA000_0009, 32'h28, 1'b0));
    // Approach the MEM_BYTES=64 boundary
    vecs.push_back(mk(1'b1, 32'h38, 1'b1, 1'b0, 32'h24, 32'hA000_0009, 32'h38, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h38, 32'hA000_000E, 32'h3C, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h3C, 32'hA000_000F, 32'h40, 1'b0));
`ifdef FETCH_BOUNDS_CHECK_EN
    // Fetch at 64 faults; redirect to 0 is ignored afterwards
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h3C, 32'hA000_000F, 32'h40, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 32'h3C, 32'hA000_000F, 32'h40, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h3C, 32'hA000_000F, 32'h40, 1'b1));
`else
    // No range check: word at 64 delivered normally
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hA000_0010, 32'h44, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'hA000_0010, 32'h00, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 32'hA000_0000, 32'h04, 1'b0));
    // PC wrap from 32'hFFFF_FFFC to 0
    vecs.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h00, 32'hA000_0000, 32'hFFFF_FFFC, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hDFFF_FFFF, 32'h00, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 32'hA000_0000, 32'h04, 1'b0));
`endif

    // ---------------- reset state ----------------
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    #3;
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr,
                vecs[i].eaddr, vecs[i].efault);
      @(negedge clk);
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    // Still well before the next rising edge
    check_all("async_reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("restart0", 1'b1, 32'h00, 32'hA000_0000, 32'h04, 1'b0);
    @(posedge clk);
    #1;
    check_all("restart1", 1'b1, 32'h04, 32'hA000_0001, 32'h08, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
